// File: rtl/bmf_approx_adder_pipe.sv
// ============================================================================
// Module   : bmf_approx_adder_pipe
// Brief    : Pipelined partitioned BMF approximate adder with error statistics.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bmf_approx_adder_pipe #(
    parameter int WIDTH    = 16,
    parameter int PART_W   = 4,
    parameter int DROP_LSB = 2,
    parameter int ERR_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             cfg_approx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic [WIDTH:0]   out_err,
    input  logic             stat_clear,
    output logic [ERR_W-1:0] stat_count,
    output logic [ERR_W-1:0] stat_err_sum,
    output logic [WIDTH:0]   stat_err_max
);

    localparam int NP = WIDTH / PART_W;
    localparam logic [PART_W-1:0] KEEP_MASK = {PART_W{1'b1}} << DROP_LSB;

    logic             en;
    logic             fire;

    logic             v_q [NP];
    logic             v_d [NP];
    logic [WIDTH-1:0] a_q [NP];
    logic [WIDTH-1:0] a_d [NP];
    logic [WIDTH-1:0] b_q [NP];
    logic [WIDTH-1:0] b_d [NP];
    logic [WIDTH-1:0] s_q [NP];
    logic [WIDTH-1:0] s_d [NP];
    logic             c_q [NP];
    logic             c_d [NP];
    logic             m_q [NP];
    logic             m_d [NP];
    logic [WIDTH:0]   x_q [NP];
    logic [WIDTH:0]   x_d [NP];

    logic             src_v [NP];
    logic [WIDTH-1:0] src_a [NP];
    logic [WIDTH-1:0] src_b [NP];
    logic [WIDTH-1:0] src_s [NP];
    logic             src_c [NP];
    logic             src_m [NP];
    logic [WIDTH:0]   src_x [NP];
    logic [PART_W:0]  p_sum [NP];

    logic [ERR_W-1:0] count_q, count_d;
    logic [ERR_W-1:0] err_sum_q, err_sum_d;
    logic [WIDTH:0]   err_max_q, err_max_d;
    logic [ERR_W:0]   sum_ext;

    assign en        = ~out_valid | out_ready;
    assign in_ready  = en;
    assign fire      = out_valid & out_ready;
    assign out_valid = v_q[NP-1];
    assign out_sum   = {c_q[NP-1], s_q[NP-1]};
    assign out_err   = (x_q[NP-1] >= out_sum) ? (x_q[NP-1] - out_sum) : (out_sum - x_q[NP-1]);

    // Stage 0 takes the raw operands; later stages see the skewed copies.
    for (genvar i = 0; i < NP; i++) begin : g_stage
        if (i == 0) begin : g_first
            assign src_v[i] = in_valid;
            assign src_a[i] = in_a;
            assign src_b[i] = in_b;
            assign src_s[i] = '0;
            assign src_c[i] = 1'b0;
            assign src_m[i] = cfg_approx;
            assign src_x[i] = {1'b0, in_a} + {1'b0, in_b};
        end else begin : g_next
            assign src_v[i] = v_q[i-1];
            assign src_a[i] = a_q[i-1];
            assign src_b[i] = b_q[i-1];
            assign src_s[i] = s_q[i-1];
            assign src_c[i] = c_q[i-1];
            assign src_m[i] = m_q[i-1];
            assign src_x[i] = x_q[i-1];
        end
        assign p_sum[i] = {1'b0, src_a[i][i*PART_W +: PART_W]}
                        + {1'b0, src_b[i][i*PART_W +: PART_W]}
                        + {{PART_W{1'b0}}, src_c[i]};
    end

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            v_d[i] = v_q[i];
            a_d[i] = a_q[i];
            b_d[i] = b_q[i];
            s_d[i] = s_q[i];
            c_d[i] = c_q[i];
            m_d[i] = m_q[i];
            x_d[i] = x_q[i];
            if (en) begin
                v_d[i] = src_v[i];
                a_d[i] = src_a[i];
                b_d[i] = src_b[i];
                s_d[i] = src_s[i];
                // Masking touches only the sum bits; the carry stays exact.
                s_d[i][i*PART_W +: PART_W] = src_m[i] ? (p_sum[i][PART_W-1:0] & KEEP_MASK)
                                                      : p_sum[i][PART_W-1:0];
                c_d[i] = p_sum[i][PART_W];
                m_d[i] = src_m[i];
                x_d[i] = src_x[i];
            end
        end
    end

    assign sum_ext = {1'b0, err_sum_q} + {1'b0, ERR_W'(out_err)};

    always_comb begin
        count_d   = count_q;
        err_sum_d = err_sum_q;
        err_max_d = err_max_q;
        if (stat_clear) begin
            count_d   = '0;
            err_sum_d = '0;
            err_max_d = '0;
        end else if (fire) begin
            count_d   = (&count_q) ? count_q : count_q + 1'b1;
            err_sum_d = sum_ext[ERR_W] ? '1 : sum_ext[ERR_W-1:0];
            if (out_err > err_max_q) begin
                err_max_d = out_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                v_q[i] <= 1'b0;
                a_q[i] <= '0;
                b_q[i] <= '0;
                s_q[i] <= '0;
                c_q[i] <= 1'b0;
                m_q[i] <= 1'b0;
                x_q[i] <= '0;
            end
            count_q   <= '0;
            err_sum_q <= '0;
            err_max_q <= '0;
        end else begin
            v_q       <= v_d;
            a_q       <= a_d;
            b_q       <= b_d;
            s_q       <= s_d;
            c_q       <= c_d;
            m_q       <= m_d;
            x_q       <= x_d;
            count_q   <= count_d;
            err_sum_q <= err_sum_d;
            err_max_q <= err_max_d;
        end
    end

    assign stat_count   = count_q;
    assign stat_err_sum = err_sum_q;
    assign stat_err_max = err_max_q;

endmodule

`default_nettype wire

// File: tb/tb_bmf_approx_adder_pipe.sv
// ============================================================================
// Module   : tb_bmf_approx_adder_pipe
// Brief    : Directed table and sequence bench for bmf_approx_adder_pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bmf_approx_adder_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        cfg_approx = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [16:0] out_sum;
    logic [16:0] out_err;
    logic        stat_clear = 1'b0;
    logic [31:0] stat_count;
    logic [31:0] stat_err_sum;
    logic [16:0] stat_err_max;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ap;
        logic [16:0] sum;
        logic [16:0] err;
    } vec_t;

    vec_t tbl [9];

    bmf_approx_adder_pipe #(.WIDTH(16), .PART_W(4), .DROP_LSB(2), .ERR_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .cfg_approx(cfg_approx),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_err(out_err), .stat_clear(stat_clear),
        .stat_count(stat_count), .stat_err_sum(stat_err_sum), .stat_err_max(stat_err_max)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, then report handshakes.
    task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b,
                        input logic ap, input logic ordy, output logic acc, output logic ofire);
        @(negedge clk);
        in_valid   = iv;
        in_a       = a;
        in_b       = b;
        cfg_approx = ap;
        out_ready  = ordy;
        #1;
        acc   = iv & in_ready;
        ofire = out_valid & out_ready;
    endtask

    // Independent reference: partition-by-partition add with masking.
    function automatic logic [16:0] model_sum(input logic [15:0] a, input logic [15:0] b, input logic ap);
        logic [16:0] r;
        logic        c;
        logic [4:0]  p;
        r = '0;
        c = 1'b0;
        for (int k = 0; k < 4; k++) begin
            p = {1'b0, a[k*4 +: 4]} + {1'b0, b[k*4 +: 4]} + {4'b0, c};
            r[k*4 +: 4] = ap ? (p[3:0] & 4'hC) : p[3:0];
            c = p[4];
        end
        r[16] = c;
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input string name);
        logic acc, of;
        int   lat;
        lat = 99;
        step(1'b1, v.a, v.b, v.ap, 1'b1, acc, of);
        check({name, "_accept"}, acc, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc, of);
            if (of) begin
                lat = k;
                break;
            end
        end
        check({name, "_latency"}, lat, 4);
        check({name, "_sum"}, out_sum, v.sum);
        check({name, "_err"}, out_err, v.err);
    endtask

    initial begin
        logic        acc, of;
        int          n_acc, got, last, gaps, cyc, sent;
        logic [15:0] bp_a [6];
        logic [33:0] exp_q [$];
        logic [33:0] e;
        logic [15:0] ra, rb;
        logic        rap;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000, 17'h00000};
        tbl[1] = '{16'hCCCC, 16'h4444, 1'b1, 17'h10000, 17'h01110};
        tbl[2] = '{16'h0000, 16'h0000, 1'b0, 17'h00000, 17'h00000};
        tbl[3] = '{16'h0003, 16'h0000, 1'b1, 17'h00000, 17'h00003};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1CCCC, 17'h03332};
        tbl[5] = '{16'h1234, 16'h4321, 1'b0, 17'h05555, 17'h00000};
        tbl[6] = '{16'h1234, 16'h4321, 1'b1, 17'h04444, 17'h01111};
        tbl[7] = '{16'h0001, 16'h0002, 1'b1, 17'h00000, 17'h00003};
        tbl[8] = '{16'h8000, 16'h8000, 1'b1, 17'h10000, 17'h00000};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_sum", out_sum, 17'h0);
        check("rst_out_err", out_err, 17'h0);
        check("rst_stat_count", stat_count, 32'h0);
        check("rst_stat_err_max", stat_err_max, 17'h0);

        for (int i = 0; i < 9; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end
        @(negedge clk);
        check("tbl_stat_count", stat_count, 32'd9);

        // Reset with two transactions in flight.
        step(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1, acc, of);
        step(1'b1, 16'h3333, 16'h4444, 1'b1, 1'b1, acc, of);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_stat_count", stat_count, 32'h0);
        check("midrst_stat_err_sum", stat_err_sum, 32'h0);
        rst = 1'b0;
        got = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc, of);
            if (out_valid) got++;
        end
        check("midrst_no_output", got, 0);

        // Statistics accumulation then clear with a simultaneous transfer.
        run_vec(tbl[1], "st0");
        run_vec(tbl[0], "st1");
        run_vec(tbl[3], "st2");
        @(negedge clk);
        check("stat_count", stat_count, 32'd3);
        check("stat_err_sum", stat_err_sum, 32'h1113);
        check("stat_err_max", stat_err_max, 17'h01110);
        step(1'b1, 16'hCCCC, 16'h4444, 1'b1, 1'b1, acc, of);
        for (int k = 1; k < 4; k++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc, of);
        @(negedge clk);
        stat_clear = 1'b1;
        #1;
        check("clr_fire", out_valid & out_ready, 1'b1);
        @(negedge clk);
        stat_clear = 1'b0;
        #1;
        check("clr_stat_count", stat_count, 32'h0);
        check("clr_stat_err_sum", stat_err_sum, 32'h0);
        check("clr_stat_err_max", stat_err_max, 17'h0);

        // Backpressure: six back-to-back inputs against a stalled consumer.
        for (int i = 0; i < 6; i++) bp_a[i] = 16'h1111 * 16'(i + 1);
        n_acc = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, bp_a[n_acc % 6], 16'h0101, 1'b0, 1'b0, acc, of);
            if (acc) n_acc++;
        end
        check("bp_accepted", n_acc, 4);
        check("bp_in_ready_low", in_ready, 1'b0);
        got = 0;
        last = -1;
        gaps = 0;
        for (int c = 0; c < 30 && got < 6; c++) begin
            step(n_acc < 6, bp_a[n_acc % 6], 16'h0101, 1'b0, 1'b1, acc, of);
            if (acc) n_acc++;
            if (of) begin
                check($sformatf("bp_out%0d", got), out_sum, {1'b0, bp_a[got]} + 17'h00101);
                if (last >= 0 && c != last + 1) gaps++;
                last = c;
                got++;
            end
        end
        check("bp_drained", got, 6);
        check("bp_back_to_back", gaps, 0);

        // Random operands, alternating mode, random consumer stalls.
        sent = 0;
        got  = 0;
        cyc  = 0;
        while ((sent < 1000 || got < 1000) && cyc < 5000) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rap = sent[0];
            step(sent < 1000, ra, rb, rap, $urandom_range(0, 3) != 0, acc, of);
            if (of) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_output", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("rnd%0d", got), {out_sum, out_err}, e);
                end
                got++;
            end
            if (acc) begin
                e[33:17] = model_sum(ra, rb, rap);
                e[16:0]  = ({1'b0, ra} + {1'b0, rb}) - e[33:17];
                exp_q.push_back(e);
                sent++;
            end
            cyc++;
        end
        check("rnd_received", got, 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
